seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  mode: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a_in  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port b_in  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse: product valid.
REQ-010 SHALL have port product  output  2*WIDTH  result {A,B}; held until the next accepted start.
REQ-011 SHALL have port x  output  1  current extension bit X of the {X,A,B} register.

Function
REQ-012 SHALL contain registers X (1 bit), A (WIDTH), B (WIDTH), S (WIDTH), mode (1 bit), and an iteration counter of $clog2(WIDTH+1) bits.
REQ-013 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 In IDLE with start=1 at a rising edge: S<=a_in, B<=b_in, A<=0, X<=0, mode<=is_signed, counter<=0, state<=RUN.
REQ-015 Each RUN cycle SHALL execute one add-shift step, m = B[0].
REQ-016 m=1, iteration not last, or unsigned mode: sum = A + S on WIDTH+1 bits (sign-extended if signed, zero-extended if unsigned).
REQ-017 m=1, signed mode, last iteration (counter = WIDTH-1): sum = A - S (A + ~S + 1) on WIDTH+1 bits.
REQ-018 m=1: X:A SHALL take sum, with X = sum[WIDTH] (signed: sign bit; unsigned: carry). m=0: X and A unchanged before the shift.
REQ-019 After the add, {X,A,B} SHALL shift right by one in the same cycle: signed mode keeps X (arithmetic shift); unsigned mode shifts in 0 and clears X.
REQ-020 counter SHALL increment each RUN cycle; after the step at counter = WIDTH-1, state<=DONE.
REQ-021 In DONE: done=1 for exactly one cycle, product={A,B}, state<=IDLE on the next edge.
REQ-022 Latency SHALL be WIDTH+1 cycles: done is high in the cycle following the WIDTH-th RUN edge after the start edge. Throughput is one multiply per WIDTH+2 cycles.
REQ-023 start SHALL be ignored while busy=1; operands and mode changing while busy SHALL not affect the result.
REQ-024 product SHALL update only on entry to DONE and hold its value in IDLE.
REQ-025 Result SHALL equal the exact 2*WIDTH-bit product for all operand pairs, including signed (-2^(WIDTH-1)) x (-2^(WIDTH-1)) and unsigned (2^WIDTH-1)^2.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, X=0, A=0, B=0, S=0, mode=0, counter=0, busy=0, done=0, product=0, x=0, regardless of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and the next start after release SHALL operate normally.

Verification
REQ-028 WIDTH=8, signed, a=-7 (0xF9), b=3 -> done at start+9 cycles, product=0xFFEB (-21).
REQ-029 WIDTH=8, unsigned, a=0xFF, b=0xFF -> product=0xFE01; signed, a=0x80, b=0x80 -> product=0x4000; signed, a=0x7F, b=0x80 -> product=0xC080.
REQ-030 start pulsed again 3 cycles after an accepted start with different operands -> ignored; first result delivered unchanged with a single done pulse.
REQ-031 reset driven low at RUN iteration 4 -> busy=0 and product=0 immediately; no done; a fresh start of 5x6 unsigned -> product=0x001E.
REQ-032 WIDTH=16, signed, a=-1 (0xFFFF), b=0x7FFF -> done at start+17 cycles, product=0xFFFF8001; b=0 with any a -> product=0.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential add-shift multiplier over an {X,A,B} register, one step per cycle.
// Signed mode subtracts the multiplicand on the last step (two's-complement weight of b's MSB).
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 x
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic               x_r, mode_r;
    logic [WIDTH-1:0]   a_r, b_r, s_r;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH:0]     ext_a, ext_s, sum;
    logic [WIDTH-1:0]   a_t, a_nx, b_nx;
    logic               x_t, x_nx, last;

    always_comb begin
        ext_a = mode_r ? {a_r[WIDTH-1], a_r} : {1'b0, a_r};
        ext_s = mode_r ? {s_r[WIDTH-1], s_r} : {1'b0, s_r};
        last  = (cnt == CW'(WIDTH - 1));
        if (mode_r && last)
            sum = ext_a + ~ext_s + (WIDTH+1)'(1);
        else
            sum = ext_a + ext_s;
        x_t  = b_r[0] ? sum[WIDTH] : x_r;
        a_t  = b_r[0] ? sum[WIDTH-1:0] : a_r;
        // Unsigned mode pulls the carry into A and refills X with zero.
        x_nx = mode_r ? x_t : 1'b0;
        a_nx = {x_t, a_t[WIDTH-1:1]};
        b_nx = {a_t[0], b_r[WIDTH-1:1]};
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_r       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            s_r       <= '0;
            mode_r    <= 1'b0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    s_r    <= a_in;
                    b_r    <= b_in;
                    a_r    <= '0;
                    x_r    <= 1'b0;
                    mode_r <= is_signed;
                    cnt    <= '0;
                end
                RUN: begin
                    x_r <= x_nx;
                    a_r <= a_nx;
                    b_r <= b_nx;
                    cnt <= cnt + CW'(1);
                    if (last) product_r <= {a_nx, b_nx};
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = product_r;
    assign x       = x_r;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier at WIDTH=8 and WIDTH=16 against an arithmetic model.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        st8 = 0, sg8 = 0, busy8, done8, x8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;
    logic        st16 = 0, sg16 = 0, busy16, done16, x16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;

    int checks = 0;
    int failures = 0;

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(st8), .is_signed(sg8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .product(p8), .x(x8));
    seq_multiplier #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(st16), .is_signed(sg16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .product(p16), .x(x16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] mask;
        sa = longint'(a & ((64'd1 << w) - 1));
        sb = longint'(b & ((64'd1 << w) - 1));
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        mask = (64'd1 << (2*w)) - 1;
        return 64'(p) & mask;
    endfunction

    function automatic logic [63:0] prod(input int w);
        return (w == 8) ? 64'(p8) : 64'(p16);
    endfunction
    function automatic logic dn(input int w);
        return (w == 8) ? done8 : done16;
    endfunction
    function automatic logic bz(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic xo(input int w);
        return (w == 8) ? x8 : x16;
    endfunction

    task automatic drive(input int w, input logic s, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin st8 = s; sg8 = sgn; a8 = a[7:0]; b8 = b[7:0]; end
        else        begin st16 = s; sg16 = sgn; a16 = a[15:0]; b16 = b[15:0]; end
    endtask

    // disturb: scramble operands/mode every busy cycle and re-pulse start 3 cycles in
    task automatic run_mul(input string tag, input int w, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input bit disturb);
        int n;
        @(negedge clk);
        drive(w, 1'b1, sgn, a, b);
        @(negedge clk);
        drive(w, 1'b0, sgn, a, b);
        chk({tag, "_busy"}, 64'(bz(w)), 64'd1);
        n = 1;
        while (!dn(w) && n < 60) begin
            if (disturb) drive(w, (n == 3), bit'($urandom_range(0, 1)), $urandom, $urandom);
            @(negedge clk);
            n++;
        end
        drive(w, 1'b0, sgn, a, b);
        chk({tag, "_latency"}, 64'(n), 64'(w + 1));
        chk({tag, "_product"}, prod(w), exp);
        chk({tag, "_x"}, 64'(xo(w)), sgn ? 64'(exp[2*w-1]) : 64'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, {62'd0, dn(w), bz(w)}, 64'd0);
        chk({tag, "_hold"}, prod(w), exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rs;
        #2;
        chk("rst8", {p8, 45'd0, busy8, done8, x8}, 64'd0);
        chk("rst16", {p16, 29'd0, busy16, done16, x16}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_mul("d_m7x3", 8, 1, 32'hF9, 32'h03, 64'hFFEB, 0);
        run_mul("d_ffxff", 8, 0, 32'hFF, 32'hFF, 64'hFE01, 0);
        run_mul("d_80x80", 8, 1, 32'h80, 32'h80, 64'h4000, 0);
        run_mul("d_7fx80", 8, 1, 32'h7F, 32'h80, 64'hC080, 0);
        run_mul("d_ign", 8, 0, 32'h0D, 32'h0B, 64'h008F, 1);
        run_mul("d16_m1x7fff", 16, 1, 32'hFFFF, 32'h7FFF, 64'hFFFF8001, 0);
        run_mul("d16_b0", 16, 1, 32'hA5C3, 32'h0000, 64'h0, 0);
        run_mul("d16_ffff2", 16, 0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001, 0);
        run_mul("d16_min2", 16, 1, 32'h8000, 32'h8000, 64'h40000000, 0);

        // abort mid-run
        @(negedge clk);
        drive(8, 1'b1, 0, 32'd100, 32'd200);
        @(negedge clk);
        drive(8, 1'b0, 0, 32'd100, 32'd200);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_state", {p8, 45'd0, busy8, done8, x8}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        begin
            int seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done8) seen++;
            end
            chk("abort_nodone", 64'(seen), 64'd0);
        end
        run_mul("post_5x6", 8, 0, 32'd5, 32'd6, 64'h001E, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rs = bit'($urandom_range(0, 1));
            run_mul("r8", 8, rs, ra, rb, model(8, rs, ra, rb), (i % 4) == 0);
            ra = $urandom; rb = $urandom; rs = bit'($urandom_range(0, 1));
            run_mul("r16", 16, rs, ra, rb, model(16, rs, ra, rb), (i % 4) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
